dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the pipelined MIPS core. It services the M-stage load/store requests issued by the controller/datapath (MemWriteM plus the ALU address).
- Models a multi-cycle memory with a fixed, parameterised access latency and accepts one outstanding request at a time.
- Drives a stall indication back toward the hazard logic so the pipeline freezes until the access completes.
- Sits between the M-stage pipeline register and the W stage, replacing the single-cycle combinational data memory.

Parameters:
- DEPTH, 256, number of 32-bit words; must be a power of 2, >= 2.
- LATENCY, 3, cycles from request accept to resp_valid; must be >= 1.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH*4.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- req_valid  in  1  M-stage memory access present (MemtoRegM | MemWriteM)
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_ready  out  1  responder can accept a request this cycle
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load data; held until the next completion
- resp_err  out  1  completion had an error (misaligned or out of range); valid with resp_valid
- stall_m  out  1  freeze F/D/E/M stages this cycle

Behaviour:
- Reset (reset == 0, async) forces state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, stall_m = 0, and latency counter = 0.
  - Memory array contents are not reset.
  - A request in flight is discarded; a pending store is not committed.
- States:
  - IDLE: req_ready = 1. On req_valid at a rising edge, capture req_we, req_addr and req_wdata, and load cnt = LATENCY-1. Go to WAIT if LATENCY > 1, else to RESP.
  - WAIT: req_ready = 0. cnt decrements each cycle; when cnt == 1, go to RESP on the next edge.
  - RESP: req_ready = 0, resp_valid = 1 for exactly one cycle, then unconditionally IDLE.
- Access commit happens on the edge entering RESP:
  - Store writes mem[index] and leaves resp_rdata unchanged.
  - Load registers mem[index] into resp_rdata.
  - index = (addr - BASE_ADDR) >> 2, truncated to $clog2(DEPTH) bits.
- Latency: accept edge to resp_valid high = exactly LATENCY cycles.
- stall_m = (state == IDLE & req_valid) | (state == WAIT). stall_m is 0 in RESP, so the pipeline advances on the completion edge and the next M-stage request is presented in the following IDLE cycle.
- Back-to-back requests: minimum spacing is LATENCY+1 cycles (one IDLE cycle between completions).
- Errors, evaluated on captured values:
  - misaligned = addr[1:0] != 0.
  - out-of-range = addr outside [BASE_ADDR, BASE_ADDR + DEPTH*4).
  - On error: the store is dropped, load resp_rdata = 0, resp_err = 1 with resp_valid. Latency is unchanged.
- Request inputs are ignored outside IDLE; changes after accept have no effect.
- Reset released mid-cycle: the next rising edge sees IDLE.

Decomposition:
- Shared package (mips_mem_pkg):
  - state encoding constants IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2
  - WORD_W = 32
  - error-cause constants
- One natural sub-module: mem_array, a synchronous single-port DEPTH x 32 RAM with one write enable. It keeps storage separate from the FSM so it can later be swapped for an SRAM macro.
- FSM, counter, address checks and stall generation stay in dmem_responder.

Test Plan:
1. Reset held low 3 cycles, then released -> req_ready = 1, stall_m = 0, resp_valid = 0, resp_rdata = 0. With LATENCY=3, store 32'hDEADBEEF to 0x10 -> stall_m high 3 cycles (IDLE + 2 WAIT), resp_valid pulses at accept+3, resp_err = 0.
2. Load 0x10 after test 1 -> resp_valid at accept+3 with resp_rdata = 32'hDEADBEEF; resp_rdata held until the next completion.
3. Back-to-back: stores to 0x0, 0x4, 0x8, then loads from 0x0, 0x4, 0x8, with req_valid held continuously -> completions exactly 4 cycles apart; loads return the stored data in order.
4. Misaligned store to 0x12, then load 0x10 -> first completion resp_err = 1 and memory unchanged; load returns the prior value with resp_err = 0. Load from BASE_ADDR + DEPTH*4 -> resp_err = 1, resp_rdata = 0.
5. Store 32'h12345678 to 0x20; assert reset during WAIT (cycle accept+1); load 0x20 after release -> no resp_valid from the aborted store, and the load returns the pre-test value (store not committed).
6. LATENCY=1 build: load 0x10 -> no WAIT state; stall_m high only in the accept cycle; resp_valid on the very next cycle.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared state encoding, word width and error causes for the data-memory responder
package mips_mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_RANGE    = 2'd2
    } err_cause_t;

    // Classify a byte offset from BASE_ADDR; a wrapped (negative) offset lands in the range error too.
    function automatic err_cause_t addr_cause(input logic [WORD_W-1:0] off, input int aw);
        return (off[1:0] != 2'b00) ? ERR_MISALIGN :
               ((off >> (aw + 2)) != '0) ? ERR_RANGE : ERR_NONE;
    endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array: single-port DEPTH x 32 storage with one write enable, kept apart from the responder FSM
module mem_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
)(
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Write on the clock edge; contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory responder with pipeline stall generation
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int                DEPTH     = 256,
    parameter int                LATENCY   = 3,
    parameter logic [WORD_W-1:0] BASE_ADDR = 32'h0000_0000
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              stall_m
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t            state, next_state;
    logic [CW-1:0]     cnt;
    logic              cap_we;
    logic [WORD_W-1:0] cap_addr, cap_wdata;
    logic              acc_we;
    logic [WORD_W-1:0] acc_addr, acc_wdata, off, rdata;
    logic              accept, commit, err;

    // Next-state and handshake outputs; the stall covers the accept cycle and every WAIT cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = req_valid ? ((LATENCY > 1) ? WAIT : RESP) : IDLE;
            WAIT:    next_state = (cnt == CW'(1)) ? RESP : WAIT;
            default: next_state = IDLE;
        endcase
        accept     = (state == IDLE) && req_valid;
        req_ready  = state == IDLE;
        resp_valid = state == RESP;
        stall_m    = accept || (state == WAIT);
    end

    // With LATENCY == 1 the commit edge is the accept edge, so the live request is used directly.
    always_comb begin
        acc_we    = (state == IDLE) ? req_we    : cap_we;
        acc_addr  = (state == IDLE) ? req_addr  : cap_addr;
        acc_wdata = (state == IDLE) ? req_wdata : cap_wdata;
        off       = acc_addr - BASE_ADDR;
        err       = addr_cause(off, AW) != ERR_NONE;
        commit    = (next_state == RESP) && (state != RESP);
    end

    mem_array #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (commit && acc_we && !err),
        .addr  (off[AW+1:2]),
        .wdata (acc_wdata),
        .rdata (rdata)
    );

    // State register, request capture and latency countdown.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                cap_we    <= req_we;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
                cnt       <= CW'(LATENCY - 1);
            end else if (state == WAIT) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // Completion status registered on the commit edge; stores leave the read data untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (commit) begin
            resp_err <= err;
            if (!acc_we) resp_rdata <= err ? '0 : rdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of two responder builds against an array model
module tb_dmem_responder;

    localparam int          DEPTH_A = 256;
    localparam int          LAT_A   = 3;
    localparam logic [31:0] BASE_A  = 32'h0000_0000;
    localparam int          DEPTH_B = 16;
    localparam int          LAT_B   = 1;
    localparam logic [31:0] BASE_B  = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        rst_n, sel, req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        a_ready, a_rv, a_err, a_stall, b_ready, b_rv, b_err, b_stall;
    logic [31:0] a_rdata, b_rdata;
    logic        rdy, rv, rerr, stall;
    logic [31:0] rdata;

    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          last_resp;
    bit          prev_keep;
    logic [31:0] ref_mem [2][DEPTH_A];
    logic [31:0] ref_rd  [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    dmem_responder #(.DEPTH(DEPTH_A), .LATENCY(LAT_A), .BASE_ADDR(BASE_A)) dut_a (
        .clk(clk), .reset(rst_n), .req_valid(req_valid && !sel), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(a_ready), .resp_valid(a_rv),
        .resp_rdata(a_rdata), .resp_err(a_err), .stall_m(a_stall)
    );

    dmem_responder #(.DEPTH(DEPTH_B), .LATENCY(LAT_B), .BASE_ADDR(BASE_B)) dut_b (
        .clk(clk), .reset(rst_n), .req_valid(req_valid && sel), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(b_ready), .resp_valid(b_rv),
        .resp_rdata(b_rdata), .resp_err(b_err), .stall_m(b_stall)
    );

    assign rdy   = sel ? b_ready : a_ready;
    assign rv    = sel ? b_rv    : a_rv;
    assign rerr  = sel ? b_err   : a_err;
    assign stall = sel ? b_stall : a_stall;
    assign rdata = sel ? b_rdata : a_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_err(input logic s, input logic [31:0] a);
        longint base = s ? longint'(BASE_B) : longint'(BASE_A);
        longint span = 4 * (s ? DEPTH_B : DEPTH_A);
        longint ofs  = longint'(a) - base;
        return (a[1:0] != 2'b00) || (ofs < 0) || (ofs >= span);
    endfunction

    function automatic int widx(input logic s, input logic [31:0] a);
        return int'((a - (s ? BASE_B : BASE_A)) / 4);
    endfunction

    function automatic logic [31:0] pick_addr(input logic s);
        int          d    = s ? DEPTH_B : DEPTH_A;
        logic [31:0] base = s ? BASE_B : BASE_A;
        int          r    = int'($urandom_range(0, 15));
        int          w    = (r < 8) ? r : d - 16 + r;
        int          k    = int'($urandom_range(0, 9));
        if (k == 0) return base + 32'(4 * w) + $urandom_range(1, 3);
        if (k == 1) return base + 32'(4 * d) + 32'(4 * $urandom_range(0, 1000));
        if (k == 2) return (base == 32'h0) ? 32'hFFFF_FFFC : base - 32'd4;
        return base + 32'(4 * w);
    endfunction

    // One request issued in an IDLE cycle (at a negedge); returns at the negedge of the following IDLE cycle.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input bit keep);
        int   lat = sel ? LAT_B : LAT_A;
        int   s   = int'(sel);
        logic exp_err;
        exp_err = model_err(sel, addr);
        if (we && !exp_err) ref_mem[s][widx(sel, addr)] = wdata;
        if (!we) ref_rd[s] = exp_err ? 32'h0 : ref_mem[s][widx(sel, addr)];
        req_we = we; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        #1;
        check("accept_ready", 32'(rdy), 32'd1);
        check("accept_stall", 32'(stall), 32'd1);
        check("accept_no_resp", 32'(rv), 32'd0);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k < lat) begin
                check("wait_no_resp", 32'(rv), 32'd0);
                check("wait_stall", 32'(stall), 32'd1);
                check("wait_ready", 32'(rdy), 32'd0);
                req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
            end
        end
        check("resp_valid", 32'(rv), 32'd1);
        check("resp_stall", 32'(stall), 32'd0);
        check("resp_ready", 32'(rdy), 32'd0);
        check("resp_err", 32'(rerr), 32'(exp_err));
        check("resp_rdata", rdata, ref_rd[s]);
        if (prev_keep) check("spacing", 32'(cyc - last_resp), 32'(lat + 1));
        last_resp = cyc;
        prev_keep = keep;
        if (!keep) req_valid = 1'b0;
        @(negedge clk);
        check("pulse_end", 32'(rv), 32'd0);
        check("idle_ready", 32'(rdy), 32'd1);
        check("rdata_held", rdata, ref_rd[s]);
        if (!keep) check("idle_stall", 32'(stall), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; prev_keep = 1'b0; last_resp = 0;
        ref_rd[0] = '0; ref_rd[1] = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(rdy), 32'd1);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_resp_valid", 32'(rv), 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_err", 32'(rerr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(rdy), 32'd1);
        check("post_rst_resp_valid", 32'(rv), 32'd0);
        xact(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        xact(1'b0, 32'h10, 32'h0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("load_hold", rdata, 32'hDEADBEEF);
        end
        xact(1'b1, 32'h0, $urandom, 1'b1);
        xact(1'b1, 32'h4, $urandom, 1'b1);
        xact(1'b1, 32'h8, $urandom, 1'b1);
        xact(1'b0, 32'h0, 32'h0, 1'b1);
        xact(1'b0, 32'h4, 32'h0, 1'b1);
        xact(1'b0, 32'h8, 32'h0, 1'b0);
        xact(1'b1, 32'h12, 32'hBAD0BAD0, 1'b0);
        xact(1'b0, 32'h10, 32'h0, 1'b0);
        xact(1'b0, BASE_A + 32'(DEPTH_A * 4), 32'h0, 1'b0);
        xact(1'b1, 32'h20, 32'hCAFE0020, 1'b0);
        for (int r = 0; r < 16; r++)
            xact(1'b1, BASE_A + 32'(4 * ((r < 8) ? r : DEPTH_A - 16 + r)), $urandom, 1'b1);
        for (int i = 0; i < 40; i++)
            xact(1'($urandom), pick_addr(1'b0), $urandom, 1'($urandom));
        req_valid = 1'b0;
        prev_keep = 1'b0;
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_valid = 1'b1;
        @(negedge clk);
        check("abort_wait_stall", 32'(stall), 32'd1);
        check("abort_wait_ready", 32'(rdy), 32'd0);
        rst_n = 1'b0;
        req_valid = 1'b0;
        ref_rd[0] = '0; ref_rd[1] = '0;
        #1;
        check("abort_ready", 32'(rdy), 32'd1);
        check("abort_stall", 32'(stall), 32'd0);
        check("abort_rdata", rdata, 32'h0);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_resp", 32'(rv), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_release_no_resp", 32'(rv), 32'd0);
        xact(1'b0, 32'h20, 32'h0, 1'b0);
        check("abort_not_committed", rdata, 32'hCAFE0020);
        sel = 1'b1;
        prev_keep = 1'b0;
        xact(1'b1, BASE_B + 32'h10, 32'h0B0B1010, 1'b0);
        xact(1'b0, BASE_B + 32'h10, 32'h0, 1'b0);
        for (int r = 0; r < 16; r++)
            xact(1'b1, BASE_B + 32'(4 * r), $urandom, 1'b1);
        for (int i = 0; i < 20; i++)
            xact(1'($urandom), pick_addr(1'b1), $urandom, 1'($urandom));
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
